ifu_lsu_mem_arbiter: RTL and testbench
======================================

Name: ifu_lsu_mem_arbiter

Overview:
- Shares the single instruction/data memory port between the IFU fetch interface and the LSU load/store interface.
- Sits between `ifu` (its `ifu_req_*` / `ifu_rsp_*` handshake) and the memory/bus slave.
- Arbitration is round-robin.
- Exactly one transaction is outstanding at a time: accept, drive, wait for response, return.
- Requests are latched, so requester signals may change after acceptance.

Parameters:
- ADDR_W, 32, address width; equals `PC_SIZE`.
- DATA_W, 32, data width; equals `INSTR_SIZE` and `XLEN`.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ifu_req_valid  in  1  IFU fetch request.
- ifu_req_ready  out  1  IFU request accepted.
- ifu_req_pc  in  ADDR_W  fetch address.
- ifu_rsp_valid  out  1  instruction returned.
- ifu_rsp_ready  in  1  IFU can take the response.
- ifu_rsp_instr  out  DATA_W  fetched instruction.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_req_addr  in  ADDR_W  access address.
- lsu_req_wen  in  1  1=store, 0=load.
- lsu_req_wdata  in  DATA_W  store data.
- lsu_req_wmask  in  DATA_W/8  byte strobes.
- lsu_rsp_valid  out  1  LSU response.
- lsu_rsp_ready  in  1  LSU can take the response.
- lsu_rsp_rdata  out  DATA_W  load data (don't-care for stores).
- mem_req_valid  out  1  downstream request.
- mem_req_ready  in  1  downstream accepts.
- mem_req_addr  out  ADDR_W  latched address.
- mem_req_wen  out  1  latched write enable.
- mem_req_wdata  out  DATA_W  latched store data.
- mem_req_wmask  out  DATA_W/8  latched strobes.
- mem_rsp_valid  in  1  downstream response.
- mem_rsp_ready  out  1  arbiter takes the response.
- mem_rsp_rdata  in  DATA_W  response data.

Behaviour:
- Clocking: single clock `clk`. `rst` is synchronous and active-high.
- Reset values:
  - state=IDLE, owner=IFU, last_grant=LSU.
  - mem_req_addr/wdata/wmask/wen = 0.
  - All valid/ready outputs = 0, except that requester readys follow the IDLE arbitration rule from the first cycle after reset.
- State IDLE:
  - Winner selection:
    - Only IFU valid -> IFU.
    - Only LSU valid -> LSU.
    - Both valid -> the requester that is not last_grant, so IFU wins the first conflict after reset.
  - Only the winner's req_ready=1, combinationally from valids; the other ready=0. With no valid requester, both readys=0.
  - On handshake:
    - latch addr/wen/wdata/wmask; IFU forces wen=0, wmask=0, wdata=0;
    - owner=winner; go to REQ.
  - mem_req_valid=0, mem_rsp_ready=0, both rsp_valid=0.
- State REQ:
  - mem_req_valid=1 with latched fields, held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready -> RSP.
  - Both requester readys=0.
- State RSP:
  - owner's rsp_valid = mem_rsp_valid and owner's rsp data = mem_rsp_rdata (combinational pass-through).
  - mem_rsp_ready = owner's rsp_ready.
  - Non-owner rsp_valid=0.
  - On mem_rsp_valid & mem_rsp_ready: last_grant=owner; go to IDLE.
- Latency:
  - Requester accept in cycle N.
  - mem_req_valid earliest in N+1.
  - Response forwarded in the same cycle it arrives.
  - Next accept earliest in the cycle after the response handshake, so the minimum round trip is 3 cycles with zero-wait memory.
- mem_rsp_valid seen in IDLE or REQ: ignored; mem_rsp_ready stays 0; no state change.
- Backpressure:
  - Requester rsp_ready=0 stalls the response; the arbiter holds RSP and downstream holds data.
  - A non-owner valid stays pending with ready=0 and is not dropped.
- Simultaneous events: the response handshake and a new request in the same cycle do not overlap; the new request is accepted next cycle in IDLE, using the updated last_grant.
- Reset mid-transaction: any state returns to IDLE next cycle and the pending transaction is abandoned. The memory slave shares `rst`, so no stale response follows.
- Round-robin fairness: under continuous contention, grants strictly alternate IFU, LSU, IFU, ...; neither requester waits more than one transaction.

Test Plan:
- Reset, then IFU only: ifu_req_pc=0x80000000, zero-wait mem returns 0x00000413 -> mem_req_addr=0x80000000 with wen=0 in cycle 1; ifu_rsp_instr=0x00000413 in cycle 2; lsu_rsp_valid stays 0.
- Both valid every cycle after reset, IFU pc 0x80000004, LSU load 0x80001000 -> grant order IFU, LSU, IFU, LSU; mem_req_addr alternates accordingly.
- LSU store addr=0x80002000, wdata=0xDEADBEEF, wmask=0xF; mem_req_ready low 3 cycles -> mem_req_* stable all 4 cycles; lsu_req_ready=0 throughout; store completes on the rsp handshake.
- IFU transaction with ifu_rsp_ready=0 for 2 cycles while mem_rsp_valid=1 -> mem_rsp_ready=0 for those cycles; data 0x12345678 delivered once ready rises; then IDLE.
- rst asserted in RSP -> next cycle state IDLE, all valids 0, last_grant=LSU; a following conflict grants IFU.
- Spurious mem_rsp_valid=1 in IDLE -> mem_rsp_ready=0; no rsp_valid to either requester.

Source files
------------

// File: rtl/ifu_lsu_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU fetch and LSU load/store
// interfaces; a single transaction is outstanding at a time.
module ifu_lsu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_pc,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic [DATA_W-1:0]     ifu_rsp_instr,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_ready,
    output logic [DATA_W-1:0]     lsu_rsp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_W-1:0]     mem_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;
    logic                  grant_ifu, grant_lsu;

    // On conflict the requester that was not served last wins.
    assign grant_ifu = ifu_req_valid & (~lsu_req_valid | (last_grant_q == OWN_LSU));
    assign grant_lsu = lsu_req_valid & (~ifu_req_valid | (last_grant_q == OWN_IFU));

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                ifu_req_ready = grant_ifu & ~rst;
                lsu_req_ready = grant_lsu & ~rst;
                if (grant_ifu) begin
                    addr_d  = ifu_req_pc;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                    owner_d = OWN_IFU;
                    state_d = S_REQ;
                end else if (grant_lsu) begin
                    addr_d  = lsu_req_addr;
                    wen_d   = lsu_req_wen;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                    owner_d = OWN_LSU;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (owner_q == OWN_IFU) begin
                    ifu_rsp_valid = mem_rsp_valid;
                    mem_rsp_ready = ifu_rsp_ready;
                end else begin
                    lsu_rsp_valid = mem_rsp_valid;
                    mem_rsp_ready = lsu_rsp_ready;
                end
                if (mem_rsp_valid && mem_rsp_ready) begin
                    last_grant_d = owner_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign ifu_rsp_instr = mem_rsp_rdata;
    assign lsu_rsp_rdata = mem_rsp_rdata;

endmodule

// File: tb/tb_ifu_lsu_mem_arbiter.sv
// Scoreboard bench for ifu_lsu_mem_arbiter: directed requests push expected memory
// requests and responses; a negedge monitor pops and compares on each handshake.
module tb_ifu_lsu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_req_pc, ifu_rsp_instr;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
    logic [3:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
    logic [3:0]  mem_req_wmask;

    logic        mem_rdy_en, spur, pend;
    logic [31:0] pdata;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    mreq_t       exp_mem[$];
    logic [31:0] exp_ifu[$];
    logic [31:0] exp_lsu[$];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ifu_lsu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_instr(ifu_rsp_instr),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 32'h0000_0413;
            32'h8000_0004: return 32'h1234_5678;
            32'h8000_1000: return 32'hCAFE_F00D;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    // Memory slave: responds one cycle after accepting a request, shares rst.
    assign mem_req_ready = mem_rdy_en;
    assign mem_rsp_valid = pend | spur;
    assign mem_rsp_rdata = pend ? pdata : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (mem_rsp_valid && mem_rsp_ready) pend <= 1'b0;
            if (mem_req_valid && mem_req_ready) begin
                pend  <= 1'b1;
                pdata <= mem_data(mem_req_addr);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req_valid && mem_req_ready) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_req_unexpected", mem_req_addr, 32'hFFFF_FFFF);
                end else begin
                    mreq_t e;
                    e = exp_mem.pop_front();
                    chk("mem_req_addr", mem_req_addr, e.addr);
                    chk("mem_req_wen", {31'd0, mem_req_wen}, {31'd0, e.wen});
                    chk("mem_req_wdata", mem_req_wdata, e.wdata);
                    chk("mem_req_wmask", {28'd0, mem_req_wmask}, {28'd0, e.wmask});
                end
            end
            if (ifu_rsp_valid && ifu_rsp_ready) begin
                if (exp_ifu.size() == 0) chk("ifu_rsp_unexpected", ifu_rsp_instr, 32'hFFFF_FFFF);
                else chk("ifu_rsp_instr", ifu_rsp_instr, exp_ifu.pop_front());
            end
            if (lsu_rsp_valid && lsu_rsp_ready) begin
                if (exp_lsu.size() == 0) chk("lsu_rsp_unexpected", lsu_rsp_rdata, 32'hFFFF_FFFF);
                else chk("lsu_rsp_rdata", lsu_rsp_rdata, exp_lsu.pop_front());
            end
            if (ifu_rsp_valid && lsu_rsp_valid)
                chk("both_rsp_valid", {31'd0, lsu_rsp_valid}, 32'd0);
        end
    end

    task automatic drive_ifu(input logic [31:0] pc, input int n);
        int got = 0;
        int cyc = 0;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = pc;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            if (ifu_req_ready) got++;
            cyc++;
            @(posedge clk); #1;
        end
        ifu_req_valid = 1'b0;
        chk("ifu_accept_count", got, n);
    endtask

    task automatic drive_lsu(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic [3:0] m, input int n);
        int got = 0;
        int cyc = 0;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = a;
        lsu_req_wen   = w;
        lsu_req_wdata = d;
        lsu_req_wmask = m;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            if (lsu_req_ready) got++;
            cyc++;
            @(posedge clk); #1;
        end
        lsu_req_valid = 1'b0;
        chk("lsu_accept_count", got, n);
    endtask

    task automatic drain();
        int done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            @(negedge clk);
            if (exp_mem.size() == 0 && exp_ifu.size() == 0 && exp_lsu.size() == 0 &&
                !mem_req_valid && !ifu_rsp_valid && !lsu_rsp_valid)
                done = 1;
        end
        chk("drain_done", done, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_pc = 0; ifu_rsp_ready = 1;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0;
        lsu_req_wmask = 0; lsu_rsp_ready = 1;
        mem_rdy_en = 1; spur = 0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
        chk("rst_ifu_rsp_valid", {31'd0, ifu_rsp_valid}, 32'd0);
        chk("rst_lsu_rsp_valid", {31'd0, lsu_rsp_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);
        chk("rst_mem_req_wdata", mem_req_wdata, 32'd0);
        chk("rst_mem_req_ctl", {27'd0, mem_req_wen, mem_req_wmask}, 32'd0);
        chk("idle_readys", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
        @(posedge clk); #1;

        // IFU only, cycle-exact latency
        exp_mem.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0});
        exp_ifu.push_back(32'h0000_0413);
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0000;
        @(negedge clk);
        chk("t1_ready_n", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd2);
        chk("t1_memv_n", {31'd0, mem_req_valid}, 32'd0);
        @(posedge clk); #1 ifu_req_valid = 1'b0;
        @(negedge clk);
        chk("t1_memv_n1", {31'd0, mem_req_valid}, 32'd1);
        @(negedge clk);
        chk("t1_rspv_n2", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd2);
        @(negedge clk);
        chk("t1_idle_n3", {29'd0, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        drain();

        // Continuous contention from reset: IFU, LSU, IFU, LSU
        do_reset();
        exp_mem.push_back('{32'h8000_0004, 1'b0, 32'h0, 4'h0});
        exp_mem.push_back('{32'h8000_1000, 1'b0, 32'h55AA_55AA, 4'h3});
        exp_mem.push_back('{32'h8000_0004, 1'b0, 32'h0, 4'h0});
        exp_mem.push_back('{32'h8000_1000, 1'b0, 32'h55AA_55AA, 4'h3});
        exp_ifu.push_back(32'h1234_5678); exp_ifu.push_back(32'h1234_5678);
        exp_lsu.push_back(32'hCAFE_F00D); exp_lsu.push_back(32'hCAFE_F00D);
        fork
            drive_ifu(32'h8000_0004, 2);
            drive_lsu(32'h8000_1000, 1'b0, 32'h55AA_55AA, 4'h3, 2);
        join
        drain();

        // LSU store with three wait cycles on mem_req_ready
        mem_rdy_en = 1'b0;
        exp_mem.push_back('{32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF});
        exp_lsu.push_back(32'h25A5_85A5);
        drive_lsu(32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1);
        lsu_req_valid = 1'b1; lsu_req_addr = 32'h1111_1111; lsu_req_wen = 1'b0;
        lsu_req_wdata = 32'h2222_2222; lsu_req_wmask = 4'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_memv", {31'd0, mem_req_valid}, 32'd1);
            chk("t3_addr", mem_req_addr, 32'h8000_2000);
            chk("t3_wdata", mem_req_wdata, 32'hDEAD_BEEF);
            chk("t3_ctl", {27'd0, mem_req_wen, mem_req_wmask}, 32'h1F);
            chk("t3_lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        lsu_req_valid = 1'b0;
        mem_rdy_en = 1'b1;
        drain();

        // IFU response held off by ifu_rsp_ready for two cycles
        ifu_rsp_ready = 1'b0;
        exp_mem.push_back('{32'h8000_0004, 1'b0, 32'h0, 4'h0});
        exp_ifu.push_back(32'h1234_5678);
        drive_ifu(32'h8000_0004, 1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_ifu_rspv", {30'd0, mem_rsp_valid, ifu_rsp_valid}, 32'd3);
            chk("t4_mem_rsp_ready", {31'd0, mem_rsp_ready}, 32'd0);
        end
        @(posedge clk); #1 ifu_rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("t4_idle", {30'd0, mem_req_valid, ifu_rsp_valid}, 32'd0);
        @(posedge clk); #1;

        // Reset while in RSP abandons the transaction
        ifu_rsp_ready = 1'b0;
        exp_mem.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0});
        drive_ifu(32'h8000_0000, 1);
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_rsp", {31'd0, ifu_rsp_valid}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_after_rst", {28'd0, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready}, 32'd0);
        ifu_rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_mem.push_back('{32'h8000_0000, 1'b0, 32'h0, 4'h0});
        exp_mem.push_back('{32'h8000_1000, 1'b0, 32'h0, 4'h0});
        exp_ifu.push_back(32'h0000_0413);
        exp_lsu.push_back(32'hCAFE_F00D);
        fork
            drive_ifu(32'h8000_0000, 1);
            drive_lsu(32'h8000_1000, 1'b0, 32'h0, 4'h0, 1);
        join
        drain();

        // Spurious memory response while idle
        spur = 1'b1;
        @(negedge clk);
        chk("t6_spurious", {29'd0, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("t6_spurious_hold", {29'd0, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
        @(posedge clk); #1 spur = 1'b0;

        // A request after the spurious pulse still completes normally
        exp_mem.push_back('{32'h8000_0004, 1'b0, 32'h0, 4'h0});
        exp_ifu.push_back(32'h1234_5678);
        drive_ifu(32'h8000_0004, 1);
        drain();

        chk("exp_mem_left", exp_mem.size(), 32'd0);
        chk("exp_ifu_left", exp_ifu.size(), 32'd0);
        chk("exp_lsu_left", exp_lsu.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
